// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, round counts and GF(2^8) / byte-permutation helpers.
// State layout: byte i = bits [127-8i -: 8], state[r][c] = byte 4c+r.
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  // One column of MixColumns; byte r of the column sits at [31-8r -: 8].
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8) (as b^254)
// followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  logic [7:0] p2_s, p4_s, p8_s, p16_s, p32_s, p64_s, p128_s;
  logic [7:0] inv_s;

  // 254 = 2+4+8+16+32+64+128, so the inverse is the product of the successive squares.
  assign p2_s   = gf_mul(a_i, a_i);
  assign p4_s   = gf_mul(p2_s, p2_s);
  assign p8_s   = gf_mul(p4_s, p4_s);
  assign p16_s  = gf_mul(p8_s, p8_s);
  assign p32_s  = gf_mul(p16_s, p16_s);
  assign p64_s  = gf_mul(p32_s, p32_s);
  assign p128_s = gf_mul(p64_s, p64_s);
  assign inv_s  = gf_mul(gf_mul(gf_mul(p2_s, p4_s), gf_mul(p8_s, p16_s)),
                         gf_mul(gf_mul(p32_s, p64_s), p128_s));

  assign s_o = inv_s
             ^ {inv_s[6:0], inv_s[7]}
             ^ {inv_s[5:0], inv_s[7:6]}
             ^ {inv_s[4:0], inv_s[7:5]}
             ^ {inv_s[3:0], inv_s[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one round per clock, round keys fetched
// externally by index through rk_idx / rk.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] plaintext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
    $error("aes_encrypt_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR - 1);
  localparam logic [3:0] FINAL_IDX  = 4'(NR);

  aes_state_e   fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q, ct_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic [3:0]   rk_idx_s;
  logic [127:0] sub_s, sr_s, mc_s;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (state_q[127 - 8*i -: 8]),
      .s_o (sub_s[127 - 8*i -: 8])
    );
  end

  assign sr_s = shift_rows(sub_s);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc_s[127 - 32*c -: 32] = mix_column(sr_s[127 - 32*c -: 32]);
  end

  // Next-state, datapath and round-key index selection.
  always_comb begin
    fsm_d    = fsm_q;
    round_d  = round_q;
    state_d  = state_q;
    ct_d     = ct_q;
    done_d   = 1'b0;
    rk_idx_s = 4'd0;
    case (fsm_q)
      IDLE: begin
        rk_idx_s = 4'd0;
        if (start) begin
          state_d = plaintext ^ rk;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end else begin
          fsm_d = IDLE;
        end
      end
      ROUND: begin
        rk_idx_s = round_q;
        state_d  = mc_s ^ rk;
        round_d  = round_q + 4'd1;
        if (round_q == LAST_ROUND) begin
          fsm_d = FINAL;
        end else begin
          fsm_d = ROUND;
        end
      end
      FINAL: begin
        rk_idx_s = FINAL_IDX;
        ct_d     = sr_s ^ rk;
        done_d   = 1'b1;
        round_d  = 4'd0;
        fsm_d    = IDLE;
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
    busy_d = (fsm_d != IDLE);
  end

  // State, round counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      round_q <= 4'd0;
      state_q <= 128'd0;
      ct_q    <= 128'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign rk_idx     = rk_idx_s;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule
